// File: rtl/alu_issue_dec.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_dec
// Brief   : Registered ALU decode/issue stage (ID->EX) with HI/LO mult/div
//           interlock, compiled in when HILO_INTERLOCK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module alu_issue_dec #(
    parameter int CTRL_W  = 5,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              div_done,
    output logic              id_ready,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_alucontrol,
    output logic              ex_ri,
    output logic              ex_md_start,
    output logic              ex_md_div,
    output logic              ex_md_signed,
    output logic              hilo_busy
);

    localparam logic [4:0] ALU_DONOTHING = 5'd0;
    localparam logic [4:0] ALU_AND       = 5'd1;
    localparam logic [4:0] ALU_OR        = 5'd2;
    localparam logic [4:0] ALU_XOR       = 5'd3;
    localparam logic [4:0] ALU_NOR       = 5'd4;
    localparam logic [4:0] ALU_SLL       = 5'd5;
    localparam logic [4:0] ALU_SRL       = 5'd6;
    localparam logic [4:0] ALU_SRA       = 5'd7;
    localparam logic [4:0] ALU_SLLV      = 5'd8;
    localparam logic [4:0] ALU_SRLV      = 5'd9;
    localparam logic [4:0] ALU_SRAV      = 5'd10;
    localparam logic [4:0] ALU_ADD       = 5'd11;
    localparam logic [4:0] ALU_ADDU      = 5'd12;
    localparam logic [4:0] ALU_SUB       = 5'd13;
    localparam logic [4:0] ALU_SUBU      = 5'd14;
    localparam logic [4:0] ALU_SLT       = 5'd15;
    localparam logic [4:0] ALU_SLTU      = 5'd16;
    localparam logic [4:0] ALU_MFHI      = 5'd17;
    localparam logic [4:0] ALU_MTHI      = 5'd18;
    localparam logic [4:0] ALU_MFLO      = 5'd19;
    localparam logic [4:0] ALU_MTLO      = 5'd20;
    localparam logic [4:0] ALU_MULT      = 5'd21;
    localparam logic [4:0] ALU_MULTU     = 5'd22;
    localparam logic [4:0] ALU_DIV       = 5'd23;
    localparam logic [4:0] ALU_DIVU      = 5'd24;
    localparam logic [4:0] ALU_LUI       = 5'd25;

    logic [4:0] w_code;
    logic       w_ri;
    logic       w_hilo;
    logic       w_md;
    logic       w_div;
    logic       w_sgn;
    logic       w_capture;

    always_comb begin
        w_code = ALU_DONOTHING;
        w_ri   = 1'b0;
        w_hilo = 1'b0;
        w_md   = 1'b0;
        w_div  = 1'b0;
        w_sgn  = 1'b0;
        if (op == 6'h00) begin
            case (funct)
                6'h24: w_code = ALU_AND;
                6'h25: w_code = ALU_OR;
                6'h26: w_code = ALU_XOR;
                6'h27: w_code = ALU_NOR;
                6'h00: w_code = ALU_SLL;
                6'h02: w_code = ALU_SRL;
                6'h03: w_code = ALU_SRA;
                6'h04: w_code = ALU_SLLV;
                6'h06: w_code = ALU_SRLV;
                6'h07: w_code = ALU_SRAV;
                6'h20: w_code = ALU_ADD;
                6'h21: w_code = ALU_ADDU;
                6'h22: w_code = ALU_SUB;
                6'h23: w_code = ALU_SUBU;
                6'h2a: w_code = ALU_SLT;
                6'h2b: w_code = ALU_SLTU;
                6'h10: begin w_code = ALU_MFHI; w_hilo = 1'b1; end
                6'h11: begin w_code = ALU_MTHI; w_hilo = 1'b1; end
                6'h12: begin w_code = ALU_MFLO; w_hilo = 1'b1; end
                6'h13: begin w_code = ALU_MTLO; w_hilo = 1'b1; end
                6'h18: begin
                    w_code = ALU_MULT;  w_hilo = 1'b1; w_md = 1'b1; w_sgn = 1'b1;
                end
                6'h19: begin
                    w_code = ALU_MULTU; w_hilo = 1'b1; w_md = 1'b1;
                end
                6'h1a: begin
                    w_code = ALU_DIV;   w_hilo = 1'b1; w_md = 1'b1; w_div = 1'b1; w_sgn = 1'b1;
                end
                6'h1b: begin
                    w_code = ALU_DIVU;  w_hilo = 1'b1; w_md = 1'b1; w_div = 1'b1;
                end
                default: w_ri = 1'b1;
            endcase
        end else begin
            // Loads, stores and branches fall through as DONOTHING without RI.
            case (op)
                6'h08:   w_code = ALU_ADD;
                6'h09:   w_code = ALU_ADDU;
                6'h0a:   w_code = ALU_SLT;
                6'h0b:   w_code = ALU_SLTU;
                6'h0c:   w_code = ALU_AND;
                6'h0d:   w_code = ALU_OR;
                6'h0e:   w_code = ALU_XOR;
                6'h0f:   w_code = ALU_LUI;
                default: w_code = ALU_DONOTHING;
            endcase
        end
    end

    assign w_capture = id_valid && id_ready && !flush_i;

`ifdef HILO_INTERLOCK_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DIV_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] C_MUL_INIT = 4'(MUL_LAT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // HI/LO-class captures only happen in IDLE because id_ready blocks them otherwise.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_capture && w_md) begin
                    if (w_div) begin
                        w_state_nxt = ST_DIV_WAIT;
                    end else begin
                        w_state_nxt = ST_MUL_BUSY;
                        w_cnt_nxt   = C_MUL_INIT;
                    end
                end
            end
            ST_MUL_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_DIV_WAIT: begin
                if (div_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign hilo_busy = (r_state != ST_IDLE);
    assign id_ready  = !stall_i && !(hilo_busy && w_hilo);
`else
    localparam int C_UNUSED_MUL_LAT = MUL_LAT;
    logic w_unused_div_done;

    assign w_unused_div_done = div_done;
    assign hilo_busy         = 1'b0;
    assign id_ready          = !stall_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_alucontrol <= CTRL_W'(ALU_DONOTHING);
            ex_ri         <= 1'b0;
            ex_md_start   <= 1'b0;
            ex_md_div     <= 1'b0;
            ex_md_signed  <= 1'b0;
        end else if (flush_i) begin
            ex_valid    <= 1'b0;
            ex_md_start <= 1'b0;
        end else if (stall_i) begin
            ex_md_start <= 1'b0;
        end else if (w_capture) begin
            ex_valid      <= 1'b1;
            ex_alucontrol <= CTRL_W'(w_code);
            ex_ri         <= w_ri;
            ex_md_start   <= w_md;
            ex_md_div     <= w_div;
            ex_md_signed  <= w_sgn;
        end else begin
            ex_valid    <= 1'b0;
            ex_md_start <= 1'b0;
        end
    end

endmodule
`default_nettype wire
